// File: rtl/shift_sweep_ctrl.sv
// Sequencer for the one-hot LED shift display: steps a one-hot pattern through a
// programmed number of bounce or wrap sweeps, holding each position dwell+1 cycles.
module shift_sweep_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DWELL_W = 4,
  parameter int SWEEP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [SWEEP_W-1:0] sweeps,
  input  logic               mode,
  output logic [WIDTH-1:0]   count,
  output logic               dir,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  state_t               state;
  logic [DWELL_W-1:0]   dwell_l;
  logic [DWELL_W-1:0]   dwell_cnt;
  logic [SWEEP_W-1:0]   sweeps_l;
  logic [SWEEP_W-1:0]   sweep_cnt;
  logic [SWEEP_W-1:0]   sweep_nxt;
  logic                 mode_l;
  logic [WIDTH-1:0]     step_count;
  logic                 step_dir;
  logic                 sweep_end;

  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign sweep_nxt = sweep_cnt + SWEEP_W'(1);

  always_comb begin
    step_count = count;
    step_dir   = dir;
    sweep_end  = 1'b0;
    if (mode_l) begin
      step_dir   = 1'b1;
      step_count = {count[WIDTH-2:0], count[WIDTH-1]};
      sweep_end  = count[WIDTH-1];
    end else if (dir) begin
      if (count[WIDTH-1]) begin
        // With WIDTH=2 the MSB is also position 2, so the reversal completes the sweep.
        if (count == TWO) begin
          step_count = ONE;
          sweep_end  = 1'b1;
        end else begin
          step_dir   = 1'b0;
          step_count = count >> 1;
        end
      end else begin
        step_count = count << 1;
      end
    end else begin
      if (count == TWO) begin
        step_count = ONE;
        step_dir   = 1'b1;
        sweep_end  = 1'b1;
      end else begin
        step_count = count >> 1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= ONE;
      dir       <= 1'b1;
      dwell_l   <= '0;
      dwell_cnt <= '0;
      sweeps_l  <= '0;
      sweep_cnt <= '0;
      mode_l    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          count <= ONE;
          dir   <= 1'b1;
          if (start && !stop) begin
            dwell_l   <= dwell;
            sweeps_l  <= sweeps;
            mode_l    <= mode;
            dwell_cnt <= '0;
            sweep_cnt <= '0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            state <= S_IDLE;
            count <= ONE;
            dir   <= 1'b1;
          end else if (dwell_cnt != dwell_l) begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
          end else begin
            dwell_cnt <= '0;
            count     <= step_count;
            dir       <= step_dir;
            if (sweep_end) begin
              sweep_cnt <= sweep_nxt;
              if (sweeps_l != '0 && sweep_nxt == sweeps_l) state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          count <= ONE;
          dir   <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          count <= ONE;
          dir   <= 1'b1;
        end
      endcase
    end
  end

endmodule
